// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes it to
// instruction memory, verifies an XOR checksum and releases the CPU on success.
module imem_boot_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [16:0] DEPTH17 = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_len_lo;
    logic [15:0]        r_len;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [1:0]         r_byte_cnt;
    logic [7:0]         r_chk;
    logic [23:0]        r_word;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic [15:0]        w_len;
    logic               w_len_bad;
    logic               w_word_last;
    logic               w_sync;

    assign w_len       = {rx_data, r_len_lo};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH17);
    assign w_word_last = ((17'(r_word_cnt) + 17'd1) == {1'b0, r_len});
    assign w_sync      = rx_valid && (rx_data == SYNC_BYTE);

    always_comb begin
        w_next = r_state;
        if (rx_valid) begin
            case (r_state)
                S_IDLE:   if (w_sync) w_next = S_LEN_LO;
                S_LEN_LO: w_next = S_LEN_HI;
                S_LEN_HI: w_next = w_len_bad ? S_ERR : S_DATA;
                S_DATA:   if (r_byte_cnt == 2'd3 && w_word_last) w_next = S_CHK;
                S_CHK:    w_next = (rx_data == r_chk) ? S_DONE : S_ERR;
                S_DONE:   w_next = S_DONE;
                S_ERR:    if (w_sync) w_next = S_LEN_LO;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cpu_reset <= (w_next != S_DONE);
            r_busy      <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                           (w_next == S_DATA)   || (w_next == S_CHK);
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_chk      <= '0;
            r_word     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    S_IDLE, S_ERR: begin
                        if (w_sync) begin
                            r_word_cnt <= '0;
                            r_byte_cnt <= '0;
                            r_chk      <= '0;
                        end
                    end
                    S_LEN_LO: r_len_lo <= rx_data;
                    S_LEN_HI: r_len    <= w_len;
                    S_DATA: begin
                        r_chk      <= r_chk ^ rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    r_word[7:0]   <= rx_data;
                            2'd1:    r_word[15:8]  <= rx_data;
                            2'd2:    r_word[23:16] <= rx_data;
                            default: begin
                                // Top byte goes straight into the write word, no extra cycle.
                                r_we       <= 1'b1;
                                r_addr     <= r_word_cnt[ADDR_W-1:0];
                                r_wdata    <= {rx_data, r_word};
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign busy       = r_busy;
    assign load_done  = r_done;
    assign load_error = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: drives framed byte streams and checks
// memory writes and status outputs against hand-computed values.
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              load_done;
    logic              load_error;

    int checkCount = 0;
    int failCount  = 0;

    logic [ADDR_W-1:0] logAddr[$];
    logic [31:0]       logData[$];
    logic [7:0]        frame[$];

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    // Each cycle imem_we is high adds one entry, so a stretched pulse shows as an extra write.
    always @(negedge clk) begin
        if (imem_we) begin
            logAddr.push_back(imem_addr);
            logData.push_back(imem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendFrame(input int maxGap);
        foreach (frame[i])
            applyStimulus(frame[i], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        logAddr.delete();
        logData.delete();
    endtask

    task automatic setGoodFrame();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    endtask

    task automatic checkGoodWrites(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(logAddr.size()), 32'd2);
        if (logAddr.size() >= 2) begin
            checkOutput({tag, "_addr0"}, 32'(logAddr[0]), 32'd0);
            checkOutput({tag, "_data0"}, logData[0], 32'h00000013);
            checkOutput({tag, "_addr1"}, 32'(logAddr[1]), 32'd1);
            checkOutput({tag, "_data1"}, logData[1], 32'h00100093);
        end
        checkOutput({tag, "_done"}, 32'(load_done), 32'd1);
        checkOutput({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
        checkOutput({tag, "_err"}, 32'(load_error), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] bigWord(input int i);
        return {8'(i), 8'(i >> 8) ^ 8'h5C, 8'(i * 3), 8'h3A ^ 8'(i)};
    endfunction

    initial begin
        logic [31:0] w;
        logic [7:0]  chk;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("rst_we", 32'(imem_we), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_wdata", imem_wdata, 32'd0);
        checkOutput("rst_cpurst", 32'(cpu_reset), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(load_done), 32'd0);
        checkOutput("rst_err", 32'(load_error), 32'd0);
        doReset();

        // Good load, back-to-back
        setGoodFrame();
        for (int i = 0; i < 11; i++) applyStimulus(frame[i], 0);
        checkOutput("good_busy_pre", 32'(busy), 32'd1);
        checkOutput("good_cpurst_pre", 32'(cpu_reset), 32'd1);
        applyStimulus(frame[11], 0);
        checkGoodWrites("good");
        checkOutput("good_hold_addr", 32'(imem_addr), 32'd1);
        checkOutput("good_hold_wdata", imem_wdata, 32'h00100093);

        // Bad checksum, then recovery with a full good frame
        doReset();
        setGoodFrame();
        frame[11] = 8'h91;
        sendFrame(0);
        checkOutput("badchk_err", 32'(load_error), 32'd1);
        checkOutput("badchk_cpurst", 32'(cpu_reset), 32'd1);
        checkOutput("badchk_done", 32'(load_done), 32'd0);
        logAddr.delete();
        logData.delete();
        setGoodFrame();
        sendFrame(0);
        checkGoodWrites("recover");

        // LEN = 0
        doReset();
        frame = '{8'hA5, 8'h00, 8'h00};
        sendFrame(0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("len0_err", 32'(load_error), 32'd1);
        checkOutput("len0_nwrites", 32'(logAddr.size()), 32'd0);

        // LEN = 0x0401
        doReset();
        frame = '{8'hA5, 8'h01, 8'h04};
        sendFrame(0);
        checkOutput("len401_err", 32'(load_error), 32'd1);
        checkOutput("len401_busy", 32'(busy), 32'd0);

        // LEN = 0x0400, full memory
        doReset();
        frame = '{8'hA5, 8'h00, 8'h04};
        chk = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w = bigWord(i);
            for (int k = 0; k < 4; k++) begin
                frame.push_back(w[8*k +: 8]);
                chk = chk ^ w[8*k +: 8];
            end
        end
        frame.push_back(chk);
        sendFrame(0);
        checkOutput("len400_nwrites", 32'(logAddr.size()), 32'd1024);
        if (logAddr.size() == 1024) begin
            checkOutput("len400_first_addr", 32'(logAddr[0]), 32'd0);
            checkOutput("len400_first_data", logData[0], bigWord(0));
            checkOutput("len400_last_addr", 32'(logAddr[1023]), 32'h3FF);
            checkOutput("len400_last_data", logData[1023], bigWord(1023));
        end
        checkOutput("len400_done", 32'(load_done), 32'd1);

        // Framing noise before the frame and bytes after DONE
        doReset();
        setGoodFrame();
        frame.push_front(8'h5A);
        frame.push_front(8'hFF);
        frame.push_front(8'h00);
        sendFrame(0);
        checkGoodWrites("noise");
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        sendFrame(0);
        checkOutput("postdone_nwrites", 32'(logAddr.size()), 32'd2);
        checkOutput("postdone_done", 32'(load_done), 32'd1);

        // Reset mid-load after the 2nd data byte of word 1
        doReset();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        sendFrame(0);
        checkOutput("midrst_pre_nwrites", 32'(logAddr.size()), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_cpurst", 32'(cpu_reset), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_we", 32'(imem_we), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_nwrites", 32'(logAddr.size()), 32'd1);
        logAddr.delete();
        logData.delete();
        setGoodFrame();
        sendFrame(0);
        checkGoodWrites("midrst_fresh");

        // Sparse strobes
        doReset();
        setGoodFrame();
        sendFrame(5);
        checkGoodWrites("sparse");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
